// File: rtl/fetch_unit.sv
// Instruction fetch stage for the multicycle RV32I core: owns the PC, issues
// word fetches over a req/ready handshake and latches the result for decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IRWrite_reg,
  input  logic        PCEn_reg,
  input  logic        PCSrc_reg,
  input  logic [31:0] target_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] instruction_reg,
  output logic [31:0] pc_reg,
  output logic [31:0] old_pc_reg,
  output logic        instr_valid,
  output logic        busy,
  output logic        misalign_err,
  output logic        fetch_err
);

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [7:0]  LAST_COUNT = 8'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  count;
  logic        pend_valid;
  logic [31:0] pend_pc;

  logic        redirect;
  logic        redirect_ok;
  logic        misalign;
  logic        start;
  logic        complete;
  logic        expire;
  logic        redirect_any;
  logic [31:0] redirect_pc;

  assign redirect    = PCEn_reg & PCSrc_reg;
  assign misalign    = redirect & (target_addr[1:0] != 2'b00);
  assign redirect_ok = redirect & (target_addr[1:0] == 2'b00);

  assign start    = (state == S_IDLE) & IRWrite_reg;
  assign complete = (state == S_WAIT) & imem_ready;
  assign expire   = (state == S_WAIT) & ~imem_ready & (count == LAST_COUNT);

  // A redirect arriving this cycle is newer than any pending one, so it wins.
  assign redirect_any = redirect_ok | pend_valid;
  assign redirect_pc  = redirect_ok ? target_addr : pend_pc;

  assign busy = (state == S_WAIT);

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: the default assignment first keeps this block purely combinational;
  // any path that left state_next unassigned would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start)              state_next = S_WAIT;
      S_WAIT:  if (complete || expire) state_next = S_IDLE;
      default:                         state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg          <= RESET_PC;
      old_pc_reg      <= RESET_PC;
      imem_addr       <= RESET_PC;
      instruction_reg <= NOP_INSTR;
      imem_req        <= 1'b0;
      instr_valid     <= 1'b0;
      misalign_err    <= 1'b0;
      fetch_err       <= 1'b0;
      count           <= 8'd0;
      pend_valid      <= 1'b0;
      pend_pc         <= 32'd0;
    end else begin
      instr_valid <= 1'b0;
      if (misalign) misalign_err <= 1'b1;

      if (start) begin
        imem_req  <= 1'b1;
        imem_addr <= pc_reg;
        count     <= 8'd0;
        // The fetch uses the old PC; a simultaneous redirect waits its turn.
        if (redirect_ok) begin
          pend_valid <= 1'b1;
          pend_pc    <= target_addr;
        end
      end else if (state == S_IDLE) begin
        if (redirect_ok) pc_reg <= target_addr;
      end else if (complete) begin
        instruction_reg <= imem_rdata;
        old_pc_reg      <= imem_addr;
        instr_valid     <= 1'b1;
        imem_req        <= 1'b0;
        pend_valid      <= 1'b0;
        pc_reg          <= redirect_any ? redirect_pc : imem_addr + 32'd4;
      end else if (expire) begin
        imem_req   <= 1'b0;
        fetch_err  <= 1'b1;
        pend_valid <= 1'b0;
        if (redirect_any) pc_reg <= redirect_pc;
      end else begin
        count <= count + 8'd1;
        if (redirect_ok) begin
          pend_valid <= 1'b1;
          pend_pc    <= target_addr;
        end
      end
    end
  end

  a_addr_stable: assert property (@(posedge clk) disable iff (reset)
    (imem_req && $past(imem_req)) |-> $stable(imem_addr));
  a_busy_req: assert property (@(posedge clk) disable iff (reset)
    busy == imem_req);
  a_valid_pulse: assert property (@(posedge clk) disable iff (reset)
    instr_valid |=> !instr_valid);

endmodule
